// File: rtl/median_window_3x3.sv
// ---------------------------------------------------------------------------
// median_window_3x3
//
// Purpose:
//   Streaming 3x3 neighbourhood generator feeding the median compare-swap
//   network. Pixels arrive in raster order, one per valid cycle. Two line
//   buffers hold the previous two lines. A 3x3 shift window combines them
//   with the incoming pixel. Every fully interior neighbourhood is presented
//   on one registered nine-pixel bus.
//
// Ports:
//   clk        sole clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data / in_sof are valid this cycle (no backpressure)
//   in_sof     marks the first pixel of a frame (row 0, col 0)
//   in_data    pixel value
//   win_valid  win_data holds a complete neighbourhood
//   win_data   nine pixels; slice [DATA_WIDTH*(3*r+c) +: DATA_WIDTH] is
//              row r (0 = oldest line) and column c (0 = leftmost)
//   win_eof    pulses with win_valid on the last window of a frame
// ---------------------------------------------------------------------------
module median_window_3x3 #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_sof,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    win_valid,
   output logic [9*DATA_WIDTH-1:0] win_data,
   output logic                    win_eof
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0]        col_q, col_d, curCol;
   logic [ROW_W-1:0]        row_q, row_d, curRow;
   logic [DATA_WIDTH-1:0]   lineBuf0_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   lineBuf1_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   lineBuf0Rd, lineBuf1Rd;
   logic [9*DATA_WIDTH-1:0] window_q, window_d;
   logic                    winValid_q, winValid_d;
   logic                    winEof_q, winEof_d;

   // A start-of-frame pixel is placed at (0,0) regardless of where the
   // counters are. The line buffers are read at that effective column, so
   // the old contents are seen before this cycle's write replaces them.
   always_comb begin
      curCol     = in_sof ? '0 : col_q;
      curRow     = in_sof ? '0 : row_q;
      lineBuf0Rd = lineBuf0_q[curCol];
      lineBuf1Rd = lineBuf1_q[curCol];
   end

   // Next-state logic. Nothing moves without an accepted pixel. The window
   // shifts left by one column and takes the vertical strip
   // {two lines back, one line back, incoming} as its new right column.
   // A window is emitted only when a full 3x3 interior neighbourhood
   // exists. The col >= 2 condition keeps windows from straddling a
   // line wrap.
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      window_d   = window_q;
      winValid_d = 1'b0;
      winEof_d   = 1'b0;
      if (in_valid) begin
         if (curCol == COL_LAST) begin
            col_d = '0;
            row_d = (curRow == ROW_LAST) ? '0 : curRow + ROW_W'(1);
         end else begin
            col_d = curCol + COL_W'(1);
            row_d = curRow;
         end
         for (int r = 0; r < 3; r++) begin
            window_d[DATA_WIDTH*(3*r)   +: DATA_WIDTH] = window_q[DATA_WIDTH*(3*r+1) +: DATA_WIDTH];
            window_d[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = window_q[DATA_WIDTH*(3*r+2) +: DATA_WIDTH];
         end
         window_d[DATA_WIDTH*2 +: DATA_WIDTH] = lineBuf1Rd;
         window_d[DATA_WIDTH*5 +: DATA_WIDTH] = lineBuf0Rd;
         window_d[DATA_WIDTH*8 +: DATA_WIDTH] = in_data;
         winValid_d = (curRow >= ROW_W'(2)) && (curCol >= COL_W'(2));
         winEof_d   = winValid_d && (curRow == ROW_LAST) && (curCol == COL_LAST);
      end
   end

   // Position counters, the window and the output flags. Reset wins over
   // a simultaneous pixel, so that pixel is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q      <= '0;
         row_q      <= '0;
         window_q   <= '0;
         winValid_q <= 1'b0;
         winEof_q   <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         window_q   <= window_d;
         winValid_q <= winValid_d;
         winEof_q   <= winEof_d;
      end
   end

   // Line buffers carry no reset because their contents only matter once
   // two fresh lines have been written. The old line-0 value cascades into
   // line 1 in the same cycle that the new pixel lands in line 0.
   always_ff @(posedge clk) begin
      if (in_valid && !rst) begin
         lineBuf1_q[curCol] <= lineBuf0Rd;
         lineBuf0_q[curCol] <= in_data;
      end
   end

   assign win_valid = winValid_q;
   assign win_data  = window_q;
   assign win_eof   = winEof_q;

endmodule

// File: tb/tb_median_window_3x3.sv
// ---------------------------------------------------------------------------
// tb_median_window_3x3
//
// Scoreboard bench for median_window_3x3 on a 4x4 image. The driver keeps
// its own picture of the frame as a 2D array indexed by (row, col). For
// every pixel that completes an interior neighbourhood, it queues the nine
// surrounding pixels, the eof flag and the cycle on which the window must
// appear. A monitor pops and compares that entry whenever the DUT raises
// win_valid.
// ---------------------------------------------------------------------------
module tb_median_window_3x3;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;

   typedef struct {
      logic [9*DW-1:0] data;
      logic            eof;
      int              due;
   } expect_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_sof = 1'b0;
   logic [DW-1:0]   in_data = '0;
   logic            win_valid;
   logic [9*DW-1:0] win_data;
   logic            win_eof;

   expect_t       expQ[$];
   logic [DW-1:0] img [H][W];
   int            mRow = 0;
   int            mCol = 0;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            winCount = 0;
   int            eofCount = 0;
   bit            gapMode = 1'b0;
   logic          prevValid = 1'b0;

   median_window_3x3 #(
      .DATA_WIDTH(DW),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_sof   (in_sof),
      .in_data  (in_data),
      .win_valid(win_valid),
      .win_data (win_data),
      .win_eof  (win_eof)
   );

   // Free-running clock and cycle counter used to time expected windows
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Generic comparison: counts every check and reports any difference
   task automatic checkOutput(input string name, input logic [9*DW-1:0] act,
                              input logic [9*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and update the reference picture. The
   // pixel's position comes from raster order with sof forcing (0,0), and
   // reset returning to (0,0) while dropping any coincident pixel.
   task automatic applyStimulus(input logic doReset, input logic valid,
                                input logic sof, input logic [DW-1:0] data);
      expect_t e;
      int r, c;
      @(posedge clk);
      #1;
      rst      = doReset;
      in_valid = valid;
      in_sof   = sof;
      in_data  = data;
      if (doReset) begin
         mRow = 0;
         mCol = 0;
      end else if (valid) begin
         r = sof ? 0 : mRow;
         c = sof ? 0 : mCol;
         img[r][c] = data;
         if (r >= 2 && c >= 2) begin
            e.data = '0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  e.data[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
            e.eof = (r == H-1) && (c == W-1);
            e.due = cyc + 1;
            expQ.push_back(e);
         end
         c++;
         if (c == W) begin
            c = 0;
            r++;
            if (r == H) r = 0;
         end
         mRow = r;
         mCol = c;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
   endtask

   // A 4x4 frame with pixel value base + 4*row + col
   task automatic sendFrame(input int base, input bit withSof, input bit gaps);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            applyStimulus(1'b0, 1'b1, withSof && r == 0 && c == 0, DW'(base + 4*r + c));
            if (gaps) idle(1);
         end
   endtask

   task automatic expectCounts(input string name, input int winStart, input int eofStart,
                               input int nWin, input int nEof);
      idle(3);
      checkOutput({name, " windows"}, 72'(winCount - winStart), 72'(nWin));
      checkOutput({name, " eofs"}, 72'(eofCount - eofStart), 72'(nEof));
   endtask

   // Monitor: every presented window must match the oldest queued one,
   // including its timing
   always @(negedge clk) begin : monitor
      expect_t e;
      if (win_valid) begin
         winCount++;
         if (win_eof) eofCount++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected window: got %h expected none", win_data);
         end else begin
            e = expQ.pop_front();
            checkOutput("win_data", win_data, e.data);
            checkOutput("win_eof", 72'(win_eof), 72'(e.eof));
            checkOutput("win latency", 72'(cyc), 72'(e.due));
         end
         if (gapMode) checkOutput("no back-to-back", 72'(prevValid), 72'(0));
      end
      prevValid = win_valid;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ws, es;
      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checkOutput("reset win_valid", 72'(win_valid), 72'(0));
      checkOutput("reset win_eof", 72'(win_eof), 72'(0));
      checkOutput("reset win_data", win_data, 72'(0));

      // Continuous frame
      $display("[TB] continuous frame");
      ws = winCount; es = eofCount;
      sendFrame(0, 1'b1, 1'b0);
      expectCounts("continuous", ws, es, 4, 1);

      // Gapped frame
      $display("[TB] gapped frame");
      ws = winCount; es = eofCount;
      gapMode = 1'b1;
      sendFrame(0, 1'b1, 1'b1);
      expectCounts("gapped", ws, es, 4, 1);
      gapMode = 1'b0;

      // Back-to-back frames, second without sof
      $display("[TB] back-to-back frames");
      ws = winCount; es = eofCount;
      sendFrame(0, 1'b1, 1'b0);
      sendFrame(100, 1'b0, 1'b0);
      expectCounts("back-to-back", ws, es, 8, 2);

      // Mid-frame sof at pixel 6, then a full new frame starting there
      $display("[TB] mid-frame sof");
      ws = winCount; es = eofCount;
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, i == 0, DW'(i));
      sendFrame(0, 1'b1, 1'b0);
      expectCounts("mid sof", ws, es, 4, 1);

      // Reset after pixel 9, then a full frame
      $display("[TB] reset after pixel 9");
      ws = winCount; es = eofCount;
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, i == 0, DW'(i));
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      sendFrame(0, 1'b1, 1'b0);
      expectCounts("reset mid", ws, es, 4, 1);

      // Reset right after an emitting pixel clears the outputs, and the
      // next frame needs no sof
      $display("[TB] reset after emitting pixel");
      ws = winCount; es = eofCount;
      for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, i == 0, DW'(50 + i));
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checkOutput("post-reset win_valid", 72'(win_valid), 72'(0));
      checkOutput("post-reset win_data", win_data, 72'(0));
      sendFrame(20, 1'b0, 1'b0);
      expectCounts("reset no sof", ws, es, 5, 1);

      // Reset together with a pixel drops that pixel
      $display("[TB] reset with valid");
      ws = winCount; es = eofCount;
      applyStimulus(1'b1, 1'b1, 1'b1, 8'd99);
      sendFrame(0, 1'b0, 1'b0);
      expectCounts("reset+valid", ws, es, 4, 1);

      // Randomised frames with gaps, occasional mid-frame sof and resets
      $display("[TB] random traffic");
      for (int f = 0; f < 8; f++) begin
         for (int p = 0; p < W*H; p++) begin
            while ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 49) == 0)
               applyStimulus(1'b1, $urandom_range(0, 1) == 1, 1'b0, DW'($urandom));
            else
               applyStimulus(1'b0, 1'b1,
                             (p == 0 && $urandom_range(0, 9) < 7) || $urandom_range(0, 39) == 0,
                             DW'($urandom));
         end
      end
      idle(4);
      checkOutput("queue drained", 72'(expQ.size()), 72'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
